// File: rtl/pd_pwr_seq.sv
// pd_pwr_seq: ordered sleep/wake sequencer for one switchable power domain (AON clock).
//
// Sleep order: idle handshake, clock off, isolation on, retention save, power off.
// Wake order is the exact mirror, with reset released last. Every step has a
// programmable dwell. Power-switch and idle acks are guarded by a timeout that
// sets a sticky error flag. Instances chain through i_parent_on / i_child_off.
//
// Ports:
//   i_aon_clk, i_soc_pwr_on_rst   always-on clock, async active-high reset
//   i_sleep_req, i_wakeup_req     sleep level request, wakeup level/pulse
//   i_pwrgate_en                  1 = full power gating, 0 = clock gate + reset only
//   i_step_dly                    per-step dwell (cycles - 1), sampled on step entry
//   i_ack_timeout                 ack timeout in cycles, 0 disables
//   i_err_clr                     clears o_err (a same-cycle set wins)
//   i_hw_sleep_ack, i_pwr_on_ack  domain idle ack, power-switch ack
//   i_parent_on, i_child_off      hierarchy gating
//   o_hw_sleep_req .. o_rstn      domain controls, decoded from registered state only
//   o_d_status, o_busy, o_err     ON indicator, in-transition indicator, sticky error
//   o_state                       current state encoding
module pd_pwr_seq #(
    parameter int unsigned DLY_W    = 8,
    parameter int unsigned TO_W     = 12,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic             i_aon_clk,
    input  logic             i_soc_pwr_on_rst,
    input  logic             i_sleep_req,
    input  logic             i_wakeup_req,
    input  logic             i_pwrgate_en,
    input  logic [DLY_W-1:0] i_step_dly,
    input  logic [TO_W-1:0]  i_ack_timeout,
    input  logic             i_err_clr,
    input  logic             i_hw_sleep_ack,
    input  logic             i_pwr_on_ack,
    input  logic             i_parent_on,
    input  logic             i_child_off,
    output logic             o_hw_sleep_req,
    output logic             o_clk_en,
    output logic             o_iso,
    output logic             o_ret,
    output logic             o_pwr_on_req,
    output logic             o_rstn,
    output logic             o_d_status,
    output logic             o_busy,
    output logic             o_err,
    output logic [3:0]       o_state
);

    // The dwell counter also times the power-on reset hold, so it must fit both.
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam int unsigned CNT_W  = (DLY_W > HOLD_W) ? DLY_W : HOLD_W;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RST_HOLD - 1);

    localparam logic [3:0] StReset  = 4'd0;
    localparam logic [3:0] StOn     = 4'd1;
    localparam logic [3:0] StSlpReq = 4'd2;
    localparam logic [3:0] StClkOff = 4'd3;
    localparam logic [3:0] StIsoOn  = 4'd4;
    localparam logic [3:0] StRetOn  = 4'd5;
    localparam logic [3:0] StPwrOff = 4'd6;
    localparam logic [3:0] StSleep  = 4'd7;
    localparam logic [3:0] StPwrUp  = 4'd8;
    localparam logic [3:0] StRestore = 4'd9;
    localparam logic [3:0] StIsoOff = 4'd10;
    localparam logic [3:0] StClkOn  = 4'd11;
    localparam logic [3:0] StRstRel = 4'd12;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] dly_q;
    logic [TO_W-1:0]  to_q;
    logic             gate_q;
    logic             wake_pend_q, wake_pend_d;
    logic             rearm_q, rearm_d;   // 1: sleep blocked until i_sleep_req seen low
    logic             err_q, err_d, err_set;
    logic             dly_done, to_fire, entering;
    logic [5:0]       outs;               // {clk_en, iso, ret, pwr_on_req, rstn, hw_sleep_req}

    assign dly_done = (dly_q == '0);
    assign to_fire  = (i_ack_timeout != '0) && (to_q == i_ack_timeout);
    assign entering = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            StReset:  if (dly_done && i_pwr_on_ack) state_d = StOn;
            StOn:     if (i_sleep_req && !wake_pend_q && !rearm_q) state_d = StSlpReq;
            StSlpReq: begin
                if (i_hw_sleep_ack && i_child_off) begin
                    state_d = StClkOff;
                end else if (i_wakeup_req || !i_sleep_req) begin
                    state_d = StOn;
                end else if (to_fire) begin
                    state_d = StOn;
                    err_set = 1'b1;
                end
            end
            StClkOff: if (dly_done) state_d = gate_q ? StIsoOn : StSleep;
            StIsoOn:  if (dly_done) state_d = StRetOn;
            StRetOn:  if (dly_done) state_d = StPwrOff;
            StPwrOff: begin
                if (!i_pwr_on_ack) state_d = StSleep;
                else if (to_fire)  err_set = 1'b1;
            end
            StSleep: begin
                if ((i_wakeup_req || wake_pend_q) && i_parent_on) begin
                    state_d = gate_q ? StPwrUp : StClkOn;
                end
            end
            StPwrUp: begin
                if (i_pwr_on_ack) state_d = StRestore;
                else if (to_fire) err_set = 1'b1;
            end
            StRestore: if (dly_done) state_d = StIsoOff;
            StIsoOff:  if (dly_done) state_d = StClkOn;
            StClkOn:   if (dly_done) state_d = StRstRel;
            StRstRel:  state_d = StOn;
            default:   state_d = StReset;
        endcase
    end

    always_comb begin
        wake_pend_d = wake_pend_q;
        if (entering && state_d == StOn) begin
            wake_pend_d = 1'b0;
        end else if (i_wakeup_req && state_q >= StClkOff && state_q <= StSleep) begin
            // Also latched in SLEEP so a pulse is held while the parent is off.
            wake_pend_d = 1'b1;
        end
        rearm_d = rearm_q & i_sleep_req;
        if (entering && state_d == StOn && state_q == StRstRel) begin
            rearm_d = i_sleep_req;
        end
        err_d = err_set | (err_q & ~i_err_clr);
    end

    always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
        if (i_soc_pwr_on_rst) begin
            state_q     <= StReset;
            dly_q       <= HOLD_INIT;
            to_q        <= '0;
            gate_q      <= 1'b0;
            wake_pend_q <= 1'b0;
            rearm_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wake_pend_q <= wake_pend_d;
            rearm_q     <= rearm_d;
            err_q       <= err_d;
            if (entering) begin
                dly_q <= CNT_W'(i_step_dly);
            end else if (!dly_done) begin
                dly_q <= dly_q - CNT_W'(1);
            end
            if (entering && (state_d == StSlpReq || state_d == StPwrOff ||
                             state_d == StPwrUp)) begin
                to_q <= '0;
            end else if (to_q != '1) begin
                to_q <= to_q + TO_W'(1);
            end
            // Gating mode is frozen for the whole sleep/wake round trip.
            if (entering && state_d == StClkOff) begin
                gate_q <= i_pwrgate_en;
            end
        end
    end

    always_comb begin
        case (state_q)
            StReset:   outs = 6'b100100;
            StOn:      outs = 6'b100110;
            StSlpReq:  outs = 6'b100111;
            StClkOff:  outs = 6'b000111;
            StIsoOn:   outs = 6'b010111;
            StRetOn:   outs = 6'b011111;
            StPwrOff:  outs = 6'b011001;
            StSleep:   outs = {1'b0, gate_q, gate_q, ~gate_q, 1'b0, 1'b1};
            StPwrUp:   outs = 6'b011101;
            StRestore: outs = 6'b010101;
            StIsoOff:  outs = 6'b000101;
            StClkOn:   outs = 6'b100101;
            StRstRel:  outs = 6'b100111;
            default:   outs = 6'b100100;
        endcase
    end

    assign {o_clk_en, o_iso, o_ret, o_pwr_on_req, o_rstn, o_hw_sleep_req} = outs;
    assign o_d_status = (state_q == StOn);
    assign o_busy     = (state_q != StOn) && (state_q != StSleep);
    assign o_err      = err_q;
    assign o_state    = state_q;

endmodule
